// File: rtl/alarm_pkg.sv
// Shared alarm definitions: state encoding, default timing and time-field widths.
package alarm_pkg;

  localparam int unsigned HR_W       = 5;
  localparam int unsigned MIN_W      = 6;
  localparam int unsigned SEC_W      = 6;
  localparam int unsigned STATE_W    = 2;
  localparam int unsigned SNZ_LEFT_W = 2;

  localparam int unsigned DEF_RING_SECS   = 60;
  localparam int unsigned DEF_SNOOZE_SECS = 300;
  localparam int unsigned DEF_MAX_SNOOZE  = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF     = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_e;

endpackage

// File: rtl/alarm_match.sv
// Alarm time comparator; trigger_c pulses on the first cycle of each match window.
module alarm_match
  import alarm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] cur_min,
  input  logic [SEC_W-1:0] cur_sec,
  input  logic [HR_W-1:0]  alm_hr,
  input  logic [MIN_W-1:0] alm_min,
  output logic             trigger_c
);

  logic match_c;
  logic match_q;

  assign match_c = (cur_hr == alm_hr) && (cur_min == alm_min) && (cur_sec == SEC_W'(0));

  // Previous-cycle match, tracked in every state so a held match never refires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) match_q <= 1'b0;
    else        match_q <= match_c;
  end

  assign trigger_c = match_c & ~match_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm scheduler: ring / snooze / dismiss / timeout sequencing and buzzer drive.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS   = DEF_RING_SECS,
  parameter int unsigned SNOOZE_SECS = DEF_SNOOZE_SECS,
  parameter int unsigned MAX_SNOOZE  = DEF_MAX_SNOOZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_1hz,
  input  logic [HR_W-1:0]       cur_hr,
  input  logic [MIN_W-1:0]      cur_min,
  input  logic [SEC_W-1:0]      cur_sec,
  input  logic [HR_W-1:0]       alm_hr,
  input  logic [MIN_W-1:0]      alm_min,
  input  logic                  alarm_en,
  input  logic                  setting_active,
  input  logic                  dismiss,
  input  logic                  snooze,
  output logic                  buzzer,
  output logic                  ringing,
  output logic                  snoozing,
  output logic [SNZ_LEFT_W-1:0] snooze_left,
  output logic [STATE_W-1:0]    state
);

  localparam int unsigned RING_W = $clog2(RING_SECS + 1);
  localparam int unsigned SNZ_W  = $clog2(SNOOZE_SECS + 1);

  alarm_state_e          state_q, state_d;
  logic [RING_W-1:0]     ring_cnt_q, ring_cnt_d;
  logic [SNZ_W-1:0]      snooze_cnt_q, snooze_cnt_d;
  logic                  beep_q, beep_d;
  logic                  buzzer_d, ringing_d, snoozing_d;
  logic [SNZ_LEFT_W-1:0] snooze_left_d;
  logic                  trigger_c;
  logic                  snooze_ok_c, ring_done_c, snz_done_c;

  alarm_match u_match (
    .clk       (clk),
    .rst_n     (rst_n),
    .cur_hr    (cur_hr),
    .cur_min   (cur_min),
    .cur_sec   (cur_sec),
    .alm_hr    (alm_hr),
    .alm_min   (alm_min),
    .trigger_c (trigger_c)
  );

  assign snooze_ok_c = snooze && (snooze_left != SNZ_LEFT_W'(0));
  assign ring_done_c = tick_1hz && (ring_cnt_q == RING_W'(RING_SECS - 1));
  assign snz_done_c  = tick_1hz && (snooze_cnt_q == SNZ_W'(1));
  assign state       = state_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  // Next state: enable first, then setting cancels an active event, then per-state rules
  always_comb begin
    state_d = state_q;
    if (!alarm_en) begin
      state_d = ST_OFF;
    end else if (setting_active && (state_q == ST_RINGING || state_q == ST_SNOOZE)) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_OFF:     state_d = ST_ARMED;
        ST_ARMED:   if (trigger_c && !setting_active) state_d = ST_RINGING;
        ST_RINGING: begin
          if (dismiss)          state_d = ST_ARMED;
          else if (snooze_ok_c) state_d = ST_SNOOZE;
          else if (ring_done_c) state_d = ST_ARMED;
        end
        ST_SNOOZE: begin
          if (dismiss)         state_d = ST_ARMED;
          else if (snz_done_c) state_d = ST_RINGING;
        end
        default:    state_d = ST_OFF;
      endcase
    end
  end

  // Next values of counters and registered outputs, keyed on the state being entered
  always_comb begin
    ring_cnt_d    = ring_cnt_q;
    snooze_cnt_d  = snooze_cnt_q;
    beep_d        = beep_q;
    snooze_left_d = snooze_left;

    if (state_d == ST_RINGING) begin
      if (state_q != ST_RINGING) begin
        ring_cnt_d = RING_W'(0);
        beep_d     = 1'b1;
      end else if (tick_1hz) begin
        if (ring_cnt_q != RING_W'(RING_SECS)) ring_cnt_d = ring_cnt_q + RING_W'(1);
        beep_d = ~beep_q;
      end
    end

    if (state_d == ST_SNOOZE) begin
      if (state_q != ST_SNOOZE) begin
        snooze_cnt_d  = SNZ_W'(SNOOZE_SECS);
        snooze_left_d = snooze_left - SNZ_LEFT_W'(1);
      end else if (tick_1hz && snooze_cnt_q != SNZ_W'(0)) begin
        snooze_cnt_d = snooze_cnt_q - SNZ_W'(1);
      end
    end

    if (state_d == ST_ARMED && state_q != ST_ARMED) snooze_left_d = SNZ_LEFT_W'(MAX_SNOOZE);

    if (state_d == ST_OFF) begin
      ring_cnt_d    = RING_W'(0);
      snooze_cnt_d  = SNZ_W'(0);
      beep_d        = 1'b0;
      snooze_left_d = SNZ_LEFT_W'(0);
    end

    buzzer_d   = (state_d == ST_RINGING) && beep_d;
    ringing_d  = (state_d == ST_RINGING);
    snoozing_d = (state_d == ST_SNOOZE);
  end

  // Counter and output registers; reset drops the buzzer immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_cnt_q   <= RING_W'(0);
      snooze_cnt_q <= SNZ_W'(0);
      beep_q       <= 1'b0;
      buzzer       <= 1'b0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
      snooze_left  <= SNZ_LEFT_W'(0);
    end else begin
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      beep_q       <= beep_d;
      buzzer       <= buzzer_d;
      ringing      <= ringing_d;
      snoozing     <= snoozing_d;
      snooze_left  <= snooze_left_d;
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl with an event-level reference model.
module tb_alarm_ctrl;
  import alarm_pkg::*;

  localparam int unsigned RING     = 4;
  localparam int unsigned SNZ      = 3;
  localparam int unsigned MAXS     = 2;
  localparam int unsigned TICK_DIV = 10;

  localparam int M_OFF   = 0;
  localparam int M_ARMED = 1;
  localparam int M_RING  = 2;
  localparam int M_SNZ   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tick_1hz;
  logic [HR_W-1:0]  cur_hr, alm_hr;
  logic [MIN_W-1:0] cur_min, alm_min;
  logic [SEC_W-1:0] cur_sec;
  logic             alarm_en, setting_active, dismiss, snooze;
  logic             buzzer, ringing, snoozing;
  logic [1:0]       snooze_left;
  logic [1:0]       state;

  typedef struct {
    int st;
    int bz;
    int rg;
    int sz;
    int left;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: mode plus "ticks elapsed ringing" and "ticks left snoozing"
  int m_mode, m_elapsed, m_srem, m_left;
  bit m_prev_match;

  alarm_ctrl #(.RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick_1hz       (tick_1hz),
    .cur_hr         (cur_hr),
    .cur_min        (cur_min),
    .cur_sec        (cur_sec),
    .alm_hr         (alm_hr),
    .alm_min        (alm_min),
    .alarm_en       (alarm_en),
    .setting_active (setting_active),
    .dismiss        (dismiss),
    .snooze         (snooze),
    .buzzer         (buzzer),
    .ringing        (ringing),
    .snoozing       (snoozing),
    .snooze_left    (snooze_left),
    .state          (state)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = M_OFF; m_elapsed = 0; m_srem = 0; m_left = 0; m_prev_match = 1'b0;
  endfunction

  function automatic void go_armed();
    m_mode = M_ARMED;
    m_left = MAXS;
  endfunction

  function automatic void model_step();
    bit match, trig;
    match = (int'(cur_hr) == int'(alm_hr)) && (int'(cur_min) == int'(alm_min)) && (cur_sec == 0);
    trig = match && !m_prev_match;
    m_prev_match = match;
    if (!alarm_en) begin
      m_mode = M_OFF; m_left = 0;
    end else if (setting_active && (m_mode == M_RING || m_mode == M_SNZ)) begin
      go_armed();
    end else if (m_mode == M_OFF) begin
      go_armed();
    end else if (m_mode == M_ARMED) begin
      if (trig && !setting_active) begin m_mode = M_RING; m_elapsed = 0; end
    end else if (m_mode == M_RING) begin
      if (dismiss) go_armed();
      else if (snooze && m_left > 0) begin m_left--; m_mode = M_SNZ; m_srem = SNZ; end
      else if (tick_1hz) begin
        m_elapsed++;
        if (m_elapsed == RING) go_armed();
      end
    end else begin
      if (dismiss) go_armed();
      else if (tick_1hz) begin
        m_srem--;
        if (m_srem == 0) begin m_mode = M_RING; m_elapsed = 0; end
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st   = m_mode;
    e.rg   = (m_mode == M_RING) ? 1 : 0;
    e.sz   = (m_mode == M_SNZ) ? 1 : 0;
    e.bz   = (m_mode == M_RING && (m_elapsed % 2) == 0) ? 1 : 0;
    e.left = m_left;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Apply current inputs for one clock, queue the model's expected post-edge outputs
  task automatic cycle();
    tick_1hz = (cyc % TICK_DIV == TICK_DIV - 1);
    cyc++;
    if (!rst_n) model_reset();
    else        model_step();
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic avoid_tick();
    while (cyc % TICK_DIV == TICK_DIV - 1) cycle();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hr = HR_W'(h); cur_min = MIN_W'(m); cur_sec = SEC_W'(s);
  endtask

  task automatic pulse_snooze();
    avoid_tick();
    snooze = 1'b1; cycle(); snooze = 1'b0;
  endtask

  task automatic pulse_dismiss();
    dismiss = 1'b1; cycle(); dismiss = 1'b0;
  endtask

  // Fresh match window at 07:30:00
  task automatic retrigger();
    set_time(7, 30, 1); run(2);
    set_time(7, 30, 0); cycle();
  endtask

  // Monitor: compare every presented output set against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",       32'(state),       e.st);
        check("buzzer",      32'(buzzer),      e.bz);
        check("ringing",     32'(ringing),     e.rg);
        check("snoozing",    32'(snoozing),    e.sz);
        check("snooze_left", 32'(snooze_left), e.left);
      end
    end
  end

  initial begin
    rst_n = 1'b0; tick_1hz = 1'b0; alarm_en = 1'b0; setting_active = 1'b0;
    dismiss = 1'b0; snooze = 1'b0;
    alm_hr = HR_W'(7); alm_min = MIN_W'(30);
    set_time(7, 29, 59);
    model_reset();
    @(negedge clk);
    run(2);
    rst_n = 1'b1;
    alarm_en = 1'b1;
    run(3);

    // Ring to timeout while holding the match time
    set_time(7, 30, 0);
    run(60);
    set_time(7, 30, 1);
    run(2);

    // Snooze twice, third snooze ignored, then timeout
    set_time(7, 30, 0); run(3);
    pulse_snooze(); run(35);
    pulse_snooze(); run(35);
    pulse_snooze(); run(50);

    // Dismiss and snooze together
    retrigger(); run(3);
    avoid_tick();
    dismiss = 1'b1; snooze = 1'b1; cycle(); dismiss = 1'b0; snooze = 1'b0;
    run(5);

    // Trigger lost under setting, then setting cancels a snooze
    setting_active = 1'b1; retrigger(); run(5); setting_active = 1'b0; run(2);
    retrigger(); run(2); pulse_snooze(); run(4);
    setting_active = 1'b1; run(3); setting_active = 1'b0; run(2);

    // Enable dropped mid-ring
    retrigger(); run(5);
    alarm_en = 1'b0; run(3); alarm_en = 1'b1; run(3);

    // Asynchronous reset mid-ring, release on the match time
    retrigger(); run(5);
    rst_n = 1'b0;
    #1;
    check("async_buzzer",  32'(buzzer),  0);
    check("async_ringing", 32'(ringing), 0);
    check("async_state",   32'(state),   M_OFF);
    cycle(); run(2);
    rst_n = 1'b1;
    run(8);

    // Day wrap: 23:59 rings, dismissed, then 00:00 rings again
    alm_hr = HR_W'(23); alm_min = MIN_W'(59);
    set_time(23, 58, 59); run(2);
    set_time(23, 59, 0); run(5);
    pulse_dismiss(); run(2);
    alm_hr = HR_W'(0); alm_min = MIN_W'(0);
    set_time(0, 0, 0); run(5);
    pulse_dismiss(); run(3);

    // Randomized traffic around the alarm time
    alm_hr = HR_W'(7); alm_min = MIN_W'(30);
    set_time(7, 30, 1);
    for (int i = 0; i < 2500; i++) begin
      alarm_en = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 99) < 2) setting_active = ~setting_active;
      if ($urandom_range(0, 29) == 0) cur_sec = SEC_W'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) cur_min = MIN_W'(30 + $urandom_range(0, 1));
      dismiss = ($urandom_range(0, 99) < 2);
      snooze  = (cyc % TICK_DIV != TICK_DIV - 1) && ($urandom_range(0, 99) < 6);
      cycle();
      dismiss = 1'b0; snooze = 1'b0;
    end
    setting_active = 1'b0; alarm_en = 1'b1;
    run(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Alarm scheduler for the clock datapath. Compares the running time against the alarm register and sequences ring, snooze, dismiss and auto-timeout. It drives the buzzer and status flags, and sits beside the mode FSM and the time/alarm registers. Time and alarm values are inputs only; this block never writes them.

Parameters:
RING_SECS, 60, number of tick_1hz pulses the alarm rings before auto-timeout (>=1)
SNOOZE_SECS, 300, number of tick_1hz pulses spent in snooze before re-ringing (>=1)
MAX_SNOOZE, 3, number of snoozes allowed per alarm event (1..3)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
tick_1hz  in  1  one-cycle pulse per second from the time counter
cur_hr  in  5  current hour, 0..23
cur_min  in  6  current minute, 0..59
cur_sec  in  6  current second, 0..59
alm_hr  in  5  alarm hour
alm_min  in  6  alarm minute
alarm_en  in  1  alarm enable switch (level)
setting_active  in  1  time or alarm setting in progress (level)
dismiss  in  1  one-cycle pulse, stop the alarm
snooze  in  1  one-cycle pulse, snooze the alarm
buzzer  out  1  beep drive
ringing  out  1  high while in RINGING
snoozing  out  1  high while in SNOOZE
snooze_left  out  2  snoozes remaining for the current event
state  out  2  current state, for display and debug

Behaviour:
- Reset (async, rst_n=0): state=OFF; buzzer, ringing and snoozing=0; snooze_left=0; all counters=0; match_q=0.
- Every output is a register, updated on the same edge as state: a causal input in cycle N is visible at N+1.
- match = (cur_hr==alm_hr) & (cur_min==alm_min) & (cur_sec==0).
- match_q <= match every cycle, in every state. trigger = match & ~match_q, so the alarm fires once per match window.
- States: OFF=0, ARMED=1, RINGING=2, SNOOZE=3. Priority within a cycle, highest first:
  1. alarm_en=0: go to OFF from any state. Clear buzzer, ringing and snoozing.
  2. setting_active=1 in RINGING or SNOOZE: go to ARMED (the alarm event is cancelled).
  3. The per-state rules below.
- OFF: alarm_en=1 -> ARMED.
- ARMED: load snooze_left=MAX_SNOOZE on entry. trigger & ~setting_active -> RINGING. A trigger while setting_active is high is lost.
- RINGING:
  - On entry: ring_cnt=0, beep_phase=1, so buzzer=1 in the first RINGING cycle.
  - Each tick_1hz: ring_cnt+1 and beep_phase toggles. buzzer = beep_phase, a 0.5 Hz on/off pattern.
  - dismiss -> ARMED.
  - Else snooze & snooze_left!=0 -> SNOOZE: snooze_left-1, snooze_cnt=SNOOZE_SECS.
  - Else snooze & snooze_left==0: ignored, ringing continues.
  - Else tick_1hz with ring_cnt==RING_SECS-1 -> ARMED (timeout after exactly RING_SECS ticks).
  - dismiss together with snooze: dismiss wins.
- SNOOZE: buzzer=0.
  - Each tick_1hz: snooze_cnt-1. A tick with snooze_cnt==1 -> RINGING (fresh ring_cnt and beep_phase).
  - dismiss -> ARMED.
  - snooze pulses and triggers are ignored.
- Leaving RINGING or SNOOZE by any path clears buzzer the next cycle.
- Counter widths: $clog2(RING_SECS+1) and $clog2(SNOOZE_SECS+1). Counters saturate and never wrap.
- Reset mid-ring: buzzer drops asynchronously. After release the block returns to ARMED without ringing: match_q is 0 in OFF, but OFF ignores trigger, and match_q=1 by the time ARMED is reached.

Decomposition:
- Package alarm_pkg: state encoding (OFF/ARMED/RINGING/SNOOZE), default RING_SECS/SNOOZE_SECS/MAX_SNOOZE, and hour/minute/second field widths (5/6/6). The time counter and the mode FSM also use these widths.
- One sub-module, alarm_match: comparator plus match_q edge detect, output trigger. The top holds the FSM, the ring/snooze counters and the buzzer register.

Test Plan:
(Bench parameters: RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2; ticks every 10 clk.)
- alarm_en=1, alm=07:30, cur steps to 07:30:00 -> ringing=1 and buzzer=1 one cycle after the match. buzzer toggles on each tick. After the 4th tick: state=ARMED, buzzer=0. Holding 07:30:00 for 3 more cycles does not retrigger.
- While ringing, pulse snooze -> SNOOZE, snooze_left=1, buzzer=0. Re-rings after exactly 3 ticks. Second snooze -> snooze_left=0. Third ring: snooze ignored, ringing stays 1, then timeout to ARMED with snooze_left reloaded to 2.
- dismiss and snooze in the same cycle during RINGING -> ARMED, snooze_left unchanged at 2.
- trigger while setting_active=1 -> stays ARMED. setting_active rising during SNOOZE -> ARMED next cycle, snoozing=0.
- alarm_en dropped mid-ring -> OFF next cycle, all outputs 0. rst_n asserted mid-ring -> buzzer=0 immediately (async). Release at cur=07:30:00 with alarm_en=1 -> ARMED, no ring.
- Match at 23:59:00, then wrap to 00:00:00 with alm=00:00 -> second distinct trigger rings again (after first dismissed).
